// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: grants ROB ids to decode, collects out-of-order
// writebacks from ALU/MEM/MUL and retires the head entry in program order.
module reorder_buffer #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRIES     = 8,
  parameter int ROB_ENTRY_WIDTH = 3,
  parameter int REG_INDEX_SIZE  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  // allocation
  input  logic                       require_rob_entry,
  input  logic                       is_store,
  input  logic [REG_INDEX_SIZE-1:0]  rd,
  output logic                       full,
  output logic [ROB_ENTRY_WIDTH-1:0] assigned_rob_id,
  // writeback ports
  input  logic                       alu_wb_bypass_enable,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       alu_wb_data,
  input  logic                       mem_wb_bypass_enable,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       mem_wb_data,
  input  logic                       mul_wb_bypass_enable,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id,
  input  logic [WORD_SIZE-1:0]       mul_wb_data,
  // operand lookup for the decode forward unit
  input  logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry,
  input  logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry,
  output logic [WORD_SIZE-1:0]       rob_s1_data,
  output logic                       rob_s1_valid,
  output logic [WORD_SIZE-1:0]       rob_s2_data,
  output logic                       rob_s2_valid,
  // commit
  output logic                       commit,
  output logic [REG_INDEX_SIZE-1:0]  commit_rd,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
  output logic                       store_commit,
  output logic                       wenable_rf,
  output logic [REG_INDEX_SIZE-1:0]  reg_in,
  output logic [WORD_SIZE-1:0]       din
);

  localparam int CNT_W = ROB_ENTRY_WIDTH + 1;

  typedef struct packed {
    logic                      busy;
    logic                      ready;
    logic                      is_store;
    logic [REG_INDEX_SIZE-1:0] rd;
    logic [WORD_SIZE-1:0]      data;
  } rob_entry_t;

  rob_entry_t                 entry_q [ROB_ENTRIES];
  logic [ROB_ENTRY_WIDTH-1:0] head_q;
  logic [ROB_ENTRY_WIDTH-1:0] tail_q;
  logic [CNT_W-1:0]           count_q;

  logic                       alloc;
  logic [ROB_ENTRIES-1:0]     wb_hit;
  logic [WORD_SIZE-1:0]       wb_data [ROB_ENTRIES];
  rob_entry_t                 head_entry;

  // Allocation handshake: require_rob_entry is the valid, !full is the ready; an id
  // is granted only in a cycle where both are high, otherwise decode holds the request.
  assign full            = (count_q == CNT_W'(ROB_ENTRIES));
  assign assigned_rob_id = tail_q;
  assign alloc           = require_rob_entry && !full;

  // Later assignments win, so port priority is mem > mul > alu on a shared id.
  always_comb begin
    for (int i = 0; i < ROB_ENTRIES; i++) begin
      wb_hit[i]  = 1'b0;
      wb_data[i] = '0;
      if (alu_wb_bypass_enable && alu_wb_rob_id == ROB_ENTRY_WIDTH'(i)) begin
        wb_hit[i]  = 1'b1;
        wb_data[i] = alu_wb_data;
      end
      if (mul_wb_bypass_enable && mul_wb_rob_id == ROB_ENTRY_WIDTH'(i)) begin
        wb_hit[i]  = 1'b1;
        wb_data[i] = mul_wb_data;
      end
      if (mem_wb_bypass_enable && mem_wb_rob_id == ROB_ENTRY_WIDTH'(i)) begin
        wb_hit[i]  = 1'b1;
        wb_data[i] = mem_wb_data;
      end
    end
  end

  assign head_entry    = entry_q[head_q];
  assign commit        = head_entry.busy && head_entry.ready;
  assign commit_rob_id = head_q;
  assign commit_rd     = head_entry.rd;
  assign reg_in        = head_entry.rd;
  assign din           = head_entry.data;
  assign store_commit  = commit && head_entry.is_store;
  assign wenable_rf    = commit && !head_entry.is_store && (head_entry.rd != '0);

  // Lookups read registered state only; same-cycle writebacks are the forward unit's job.
  assign rob_s1_data  = entry_q[rs1_rob_entry].data;
  assign rob_s1_valid = entry_q[rs1_rob_entry].busy && entry_q[rs1_rob_entry].ready;
  assign rob_s2_data  = entry_q[rs2_rob_entry].data;
  assign rob_s2_valid = entry_q[rs2_rob_entry].busy && entry_q[rs2_rob_entry].ready;

  // The tail slot is never busy while allocation is possible, so alloc and commit
  // never target the same entry; the commit clear is placed last so it always wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        if (wb_hit[i] && entry_q[i].busy) begin
          entry_q[i].ready <= 1'b1;
          entry_q[i].data  <= wb_data[i];
        end
        if (alloc && tail_q == ROB_ENTRY_WIDTH'(i)) begin
          entry_q[i].busy     <= 1'b1;
          entry_q[i].ready    <= 1'b0;
          entry_q[i].is_store <= is_store;
          entry_q[i].rd       <= rd;
        end
        if (commit && head_q == ROB_ENTRY_WIDTH'(i)) begin
          entry_q[i].busy  <= 1'b0;
          entry_q[i].ready <= 1'b0;
        end
      end
      if (alloc) begin
        tail_q <= tail_q + ROB_ENTRY_WIDTH'(1);
      end
      if (commit) begin
        head_q <= head_q + ROB_ENTRY_WIDTH'(1);
      end
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(commit);
    end
  end

endmodule
